// File: rtl/myproject_div_pkg.sv
// Shared types and saturation limits for the sequential signed divider.
package myproject_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/myproject_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module myproject_div_step
    import myproject_div_pkg::*;
#(
    parameter int W = 11
) (
    input  logic [W:0]   i_rem,
    input  logic         i_bit,
    input  logic [W-1:0] i_div,
    output logic         o_q,
    output logic [W:0]   o_rem
);

    logic [W+1:0] w_shift;
    logic [W+1:0] w_diff;

    // The partial remainder stays below the divisor, so the top bit of the difference is a clean borrow.
    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_div};
    assign o_q     = ~w_diff[W+1];
    assign o_rem   = o_q ? w_diff[W:0] : w_shift[W:0];

endmodule

// File: rtl/myproject_sdiv_27s_11ns_16_seq.sv
// Sequential signed/unsigned restoring divider with saturating quotient.
// Define MYPROJECT_SDIV_REM_EN to add the signed remainder output dout_rem.
module myproject_sdiv_27s_11ns_16_seq
    import myproject_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 27,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         start,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0]        din1,
    output logic                         busy,
    output logic                         done,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         sat,
    output logic                         dz
`ifdef MYPROJECT_SDIV_REM_EN
    ,
    output logic signed [din1_WIDTH:0]   dout_rem
`endif
);

    localparam int QW    = din0_WIDTH;
    localparam int RW    = din1_WIDTH + 1;
    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [CNT_W-1:0]      LAST     = CNT_W'(din0_WIDTH - 1);
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = dout_WIDTH'(sat_max(dout_WIDTH));
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = dout_WIDTH'(sat_min(dout_WIDTH));
    localparam logic [63:0]           POS_LIM  = 64'(sat_max(dout_WIDTH));
    localparam logic [63:0]           NEG_LIM  = 64'(-sat_min(dout_WIDTH));

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [QW:0]         r_mag;
    logic [RW-1:0]       r_rem;
    logic [din1_WIDTH-1:0] r_div;
    logic                r_neg;

    logic signed [QW:0]  w_ext;
    logic [QW:0]         w_abs;
    logic                w_accept;
    logic                w_q;
    logic [RW-1:0]       w_rem;
    logic                w_dz;
    logic [dout_WIDTH:0] w_res;

    function automatic logic [dout_WIDTH:0] f_sign_sat(input logic [QW:0] mag, input logic neg);
        logic [63:0] m;
        m = 64'(mag);
        if (neg) begin
            if (m > NEG_LIM) return {1'b1, DOUT_MIN};
            return {1'b0, dout_WIDTH'(~m + 64'd1)};
        end
        if (m > POS_LIM) return {1'b1, DOUT_MAX};
        return {1'b0, m[dout_WIDTH-1:0]};
    endfunction

`ifdef MYPROJECT_SDIV_REM_EN
    function automatic logic [RW-1:0] f_sign_rem(input logic [RW-1:0] rem, input logic neg,
                                                 input logic zdiv);
        if (zdiv) return '0;
        return neg ? (~rem + 1'b1) : rem;
    endfunction
`endif

    // One extra bit keeps |-2^(QW-1)| representable.
    assign w_ext    = {din0[QW-1], din0};
    assign w_abs    = din0[QW-1] ? -w_ext : w_ext;
    assign w_accept = (r_state == IDLE) && start && !done;
    assign w_dz     = (r_div == '0);
    assign w_res    = w_dz ? {1'b1, (r_neg ? DOUT_MIN : DOUT_MAX)} : f_sign_sat(r_mag, r_neg);

    myproject_div_step #(
        .W(din1_WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_mag[QW-1]),
        .i_div (r_div),
        .o_q   (w_q),
        .o_rem (w_rem)
    );

    // Datapath: quotient bits replace dividend bits from the LSB as the dividend shifts out.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (w_accept) begin
                r_mag <= w_abs;
                r_neg <= din0[QW-1];
                r_div <= din1;
                r_rem <= '0;
            end else if (r_state == CALC) begin
                r_mag <= {1'b0, r_mag[QW-2:0], w_q};
                r_rem <= w_rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            sat      <= 1'b0;
            dz       <= 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
            dout_rem <= '0;
`endif
        end else if (ce) begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= CALC;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= FIN;
                end
                FIN: begin
                    {sat, dout} <= w_res;
                    dz          <= w_dz;
`ifdef MYPROJECT_SDIV_REM_EN
                    dout_rem    <= f_sign_rem(r_rem, r_neg, w_dz);
`endif
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_myproject_sdiv_27s_11ns_16_seq.sv
// Bench for the sequential divider: vector table, random vectors and timing corner sequences.
module tb_myproject_sdiv_27s_11ns_16_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, ce, start;
    logic signed [26:0] din0;
    logic [10:0]        din1;
    logic               busy, done, sat, dz;
    logic signed [15:0] dout;
`ifdef MYPROJECT_SDIV_REM_EN
    logic signed [11:0] dout_rem;
`endif

    myproject_sdiv_27s_11ns_16_seq #(
        .ID(1), .din0_WIDTH(27), .din1_WIDTH(11), .dout_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start),
        .din0(din0), .din1(din1),
        .busy(busy), .done(done), .dout(dout), .sat(sat), .dz(dz)
`ifdef MYPROJECT_SDIV_REM_EN
        , .dout_rem(dout_rem)
`endif
    );

    typedef struct { longint d0; longint d1; int q; bit sat; bit dz; } vec_t;
    typedef struct { int q; bit sat; bit dz; int rem; int cyc; } exp_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    bit     prev_done = 1'b0;
    exp_t   sb[$];
    vec_t   vecs[16];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model(input longint d0, input longint d1);
        exp_t   e;
        longint q;
        e.cyc = 0;
        if (d1 == 0) begin
            e.dz = 1'b1; e.sat = 1'b1; e.rem = 0;
            e.q  = (d0 < 0) ? -32768 : 32767;
        end else begin
            q     = d0 / d1;
            e.rem = int'(d0 % d1);
            e.dz  = 1'b0;
            e.sat = 1'b0;
            if (q > 32767)       begin q = 32767;  e.sat = 1'b1; end
            else if (q < -32768) begin q = -32768; e.sat = 1'b1; end
            e.q = int'(q);
        end
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        if (done === 1'b1 && !prev_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: done=1, expected no result", cyc);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("dout", dout, e.q);
                check("sat", sat, e.sat);
                check("dz", dz, e.dz);
                check("busy_at_done", busy, 0);
`ifdef MYPROJECT_SDIV_REM_EN
                check("dout_rem", dout_rem, e.rem);
`endif
            end
        end
        prev_done = (done === 1'b1);
    endtask

    task automatic step_neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        step_neg();
        step_pos();
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout at cycle %0d: %0d results outstanding, expected 0", cyc, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input longint d0, input longint d1, input exp_t e_in);
        exp_t e;
        e = e_in;
        wait_ready();
        din0  = 27'(d0);
        din1  = 11'(d1);
        start = 1'b1;
        e.cyc = cyc + 29;
        sb.push_back(e);
        step();
        start = 1'b0;
        din0  = 27'($urandom);
        din1  = 11'($urandom);
        step_neg();
        check("busy_after_start", busy, 1);
        step_pos();
        wait_empty(40);
    endtask

    initial begin
        exp_t               e;
        logic signed [26:0] r0;
        longint             d1;
        int                 s;

        vecs[0]  = '{1000, 7, 142, 1'b0, 1'b0};
        vecs[1]  = '{-1000, 7, -142, 1'b0, 1'b0};
        vecs[2]  = '{-67108864, 1, -32768, 1'b1, 1'b0};
        vecs[3]  = '{67108863, 1, 32767, 1'b1, 1'b0};
        vecs[4]  = '{-5, 0, -32768, 1'b1, 1'b1};
        vecs[5]  = '{100, 3, 33, 1'b0, 1'b0};
        vecs[6]  = '{5, 0, 32767, 1'b1, 1'b1};
        vecs[7]  = '{0, 0, 32767, 1'b1, 1'b1};
        vecs[8]  = '{-1, 2047, 0, 1'b0, 1'b0};
        vecs[9]  = '{67108863, 2047, 32767, 1'b1, 1'b0};
        vecs[10] = '{-67108864, 2047, -32768, 1'b1, 1'b0};
        vecs[11] = '{65534, 2, 32767, 1'b0, 1'b0};
        vecs[12] = '{65536, 2, 32767, 1'b1, 1'b0};
        vecs[13] = '{-65536, 2, -32768, 1'b0, 1'b0};
        vecs[14] = '{-65538, 2, -32768, 1'b1, 1'b0};
        vecs[15] = '{-7, 1000, 0, 1'b0, 1'b0};

        // Reset with ce low must still clear everything.
        reset = 1'b1; ce = 1'b0; start = 1'b0; din0 = '0; din1 = '0;
        step_pos();
        for (int i = 0; i < 3; i++) step();
        step_neg();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dout", dout, 0);
        check("rst_sat", sat, 0);
        check("rst_dz", dz, 0);
        step_pos();
        reset = 1'b0;
        ce    = 1'b1;

        for (int i = 0; i < 16; i++) begin
            e     = model(vecs[i].d0, vecs[i].d1);
            e.q   = vecs[i].q;
            e.sat = vecs[i].sat;
            e.dz  = vecs[i].dz;
            run_op(vecs[i].d0, vecs[i].d1, e);
        end

        for (int i = 0; i < 16; i++) begin
            r0 = 27'($urandom);
            d1 = (i % 4 == 0) ? longint'($urandom_range(1, 15)) : longint'(11'($urandom));
            run_op(r0, d1, model(r0, d1));
        end

        // ce gap of 5 cycles delays done by 5; a start during CALC is ignored.
        wait_ready();
        s = cyc;
        din0 = 27'(1000); din1 = 11'(7); start = 1'b1;
        e = model(1000, 7); e.cyc = s + 34;
        sb.push_back(e);
        for (int k = 1; k <= 36; k++) begin
            step();
            start = (k == 5);
            if (k == 5) begin din0 = 27'(12345); din1 = 11'(3); end
            ce = (k < 10 || k > 14);
        end
        start = 1'b0; ce = 1'b1;
        wait_empty(10);

        // done stretches while ce=0; start during the done cycle is ignored.
        wait_ready();
        s = cyc;
        din0 = -27'sd1000; din1 = 11'(7); start = 1'b1;
        e = model(-1000, 7); e.cyc = s + 29;
        sb.push_back(e);
        for (int k = 0; k <= 32; k++) begin
            step_neg();
            if (k >= 29 && k <= 31) check("done_stretch", done, 1);
            if (k == 32) begin
                check("done_after_stretch", done, 0);
                check("start_in_done_ignored", busy, 0);
            end
            step_pos();
            start = (k + 1 == 31);
            ce    = !((k + 1 == 29) || (k + 1 == 30));
            din0  = 27'(77); din1 = 11'(1);
        end
        start = 1'b0; ce = 1'b1;
        wait_empty(40);

        // Reset mid-operation aborts it; start on the first post-reset cycle is accepted.
        wait_ready();
        s = cyc;
        din0 = 27'(5000); din1 = 11'(7); start = 1'b1;
        e = model(5000, 7); e.cyc = s + 29;
        sb.push_back(e);
        for (int k = 0; k <= 11; k++) begin
            step_neg();
            if (k == 11) begin
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
            end
            step_pos();
            start = 1'b0;
            reset = (k + 1 == 10);
            if (k + 1 == 10) sb.delete();
            if (k + 1 == 11) begin
                din0 = 27'(100); din1 = 11'(3); start = 1'b1;
                e = model(100, 3); e.cyc = s + 40;
                sb.push_back(e);
            end
        end
        start = 1'b0;
        wait_empty(40);

        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/myproject_sdiv_27s_11ns_16_seq.md
MYPROJECT_SDIV_27S_11NS_16_SEQ -- requirements
Module: myproject_sdiv_27s_11ns_16_seq

Interface
REQ-001 Parameters SHALL be: ID, 1, instance tag with no functional effect; din0_WIDTH, 27, dividend width; din1_WIDTH, 11, divisor width; dout_WIDTH, 16, quotient width.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ce  input  1  clock enable; when 0, every register holds its value.
REQ-005 start  input  1  request; sampled only in IDLE with ce=1.
REQ-006 din0  input  din0_WIDTH  signed dividend (two's complement).
REQ-007 din1  input  din1_WIDTH  unsigned divisor, zero-extended internally.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle pulse; qualifies dout, sat and dz.
REQ-010 dout  output  dout_WIDTH  signed quotient, held until the next done.
REQ-011 sat  output  1  quotient was clamped; held with dout.
REQ-012 dz  output  1  divisor was zero; held with dout.

Function
REQ-013 The quotient SHALL truncate toward zero: dout = trunc(din0 / din1), then clamp to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
REQ-014 The state machine SHALL have three states: IDLE, CALC and FIN.
REQ-015 IDLE->CALC SHALL occur on start=1 with ce=1, latching |din0|, the sign of din0 and din1, and clearing the bit counter.
REQ-016 CALC SHALL perform one restoring step per ce=1 cycle, MSB first, for exactly din0_WIDTH steps, then go to FIN.
REQ-017 FIN SHALL apply the sign, saturate, register dout/sat/dz, pulse done and go to IDLE.
REQ-018 Latency: with start accepted at cycle 0 and ce=1 throughout, done SHALL be high at cycle din0_WIDTH+2 (29 by default).
REQ-019 Each ce=0 cycle SHALL delay done by exactly one cycle; a done pulse SHALL stretch while ce=0.
REQ-020 start SHALL be ignored while busy=1 or in the done cycle; no queuing.
REQ-021 din0 and din1 SHALL be don't-care after the acceptance cycle.
REQ-022 When din1=0: dz=1, sat=1, dout = 2^(dout_WIDTH-1)-1 for din0>=0, else -2^(dout_WIDTH-1); timing SHALL be unchanged.
REQ-023 The dividend -2^(din0_WIDTH-1) SHALL be handled; its magnitude path is din0_WIDTH+1 bits wide.
REQ-024 The remainder register SHALL be din1_WIDTH+1 bits wide, so the restoring subtract never overflows.

Reset
REQ-025 On reset=1 at a clock edge, regardless of ce: state=IDLE, busy=0, done=0, dout=0, sat=0, dz=0, and the counter is cleared.
REQ-026 Reset during CALC or FIN SHALL abort the operation with no done pulse; a start on the first post-reset cycle SHALL be accepted.

Configuration
REQ-027 With macro MYPROJECT_SDIV_REM_EN defined, the block SHALL add output dout_rem (din1_WIDTH+1 bits, signed) carrying the remainder, with the sign of din0, valid with done, reset to 0, and 0 when dz=1.
REQ-028 Without MYPROJECT_SDIV_REM_EN, dout_rem and its output register SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Shared package myproject_div_pkg SHALL hold the state typedef (IDLE/CALC/FIN) and the saturation-limit constant functions.
REQ-030 One combinational sub-module, myproject_div_step, SHALL implement a single restoring step: shift in a bit, trial subtract, and output the quotient bit and the new remainder.

Verification
REQ-031 din0=1000, din1=7, ce=1 -> done at cycle 29, dout=142, sat=0, dz=0 (dout_rem=6 if enabled).
REQ-032 din0=-1000, din1=7 -> dout=-142 (dout_rem=-6); din0=-67108864, din1=1 -> dout=-32768, sat=1.
REQ-033 din0=67108863, din1=1 -> dout=32767, sat=1; din0=-5, din1=0 -> dout=-32768, dz=1, sat=1.
REQ-034 ce=0 for 5 cycles at cycles 10-14 -> done at cycle 34 with the same dout; start pulsed at cycle 5 -> ignored.
REQ-035 reset at cycle 10 -> busy=0 and done never pulses; start at cycle 11 with 100/3 -> dout=33 at cycle 40.
